// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with a two-entry skid buffer on its output

package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    alu_op_e alu_op;
    logic    use_imm;
    logic    is_branch;
  } ctrl_t;

endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_is_jump,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam int CW    = $bits(ctrl_t);
  localparam int BUS_W = CW + 15 + XLEN + PC_W + 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Decoded fields of the incoming instruction
  ctrl_t             dec_ctrl;
  logic [4:0]        dec_rs1;
  logic [31:0]       dec_imm32;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              dec_is_jump;
  logic              dec_illegal;
  logic [BUS_W-1:0]  dec_bus;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Combinational instruction decode; illegal encodings leave all side-effect flags clear
  always_comb begin
    dec_ctrl      = '0;
    dec_ctrl.alu_op = ALU_ADD;
    dec_rs1       = in_inst[19:15];
    dec_imm32     = '0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_is_jump   = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_ctrl.reg_write = 1'b1;
        case (funct3)
          3'b000: dec_ctrl.alu_op = (funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
          3'b111: dec_ctrl.alu_op = ALU_AND;
          3'b110: dec_ctrl.alu_op = ALU_OR;
          3'b100: dec_ctrl.alu_op = ALU_XOR;
          3'b001: dec_ctrl.alu_op = ALU_SLL;
          3'b101: dec_ctrl.alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
          default: dec_illegal = 1'b1;
        endcase
        if (funct7 != 7'h00 && funct7 != 7'h20) dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.use_imm   = 1'b1;
        dec_imm32          = imm_i;
        case (funct3)
          3'b111: dec_ctrl.alu_op = ALU_AND;
          3'b110: dec_ctrl.alu_op = ALU_OR;
          3'b100: dec_ctrl.alu_op = ALU_XOR;
          3'b001: dec_ctrl.alu_op = ALU_SLL;
          3'b101: dec_ctrl.alu_op = in_inst[30] ? ALU_SRA : ALU_SRL;
          default: dec_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OPC_LOAD: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.use_imm   = 1'b1;
        dec_mem_read       = 1'b1;
        dec_imm32          = imm_i;
      end
      OPC_STORE: begin
        dec_ctrl.use_imm = 1'b1;
        dec_mem_write    = 1'b1;
        dec_imm32        = imm_s;
      end
      OPC_BRANCH: begin
        dec_ctrl.is_branch = 1'b1;
        dec_ctrl.alu_op    = ALU_SUB;
        dec_imm32          = imm_b;
      end
      OPC_LUI: begin
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.use_imm   = 1'b1;
        dec_rs1            = 5'd0;
        dec_imm32          = imm_u;
      end
      OPC_JAL: begin
        dec_ctrl.reg_write = 1'b1;
        dec_is_jump        = 1'b1;
        dec_imm32          = imm_j;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_ctrl.reg_write = 1'b0;
      dec_ctrl.is_branch = 1'b0;
      dec_mem_read       = 1'b0;
      dec_mem_write      = 1'b0;
      dec_is_jump        = 1'b0;
    end
  end

  assign dec_bus = {dec_ctrl, dec_rs1, in_inst[24:20], in_inst[11:7],
                    XLEN'(signed'(dec_imm32)), in_pc,
                    dec_mem_read, dec_mem_write, dec_is_jump, dec_illegal};

  // Skid buffer control
  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [BUS_W-1:0] main_q, skid_q;
  logic             accept, xfer;
  logic             load_main_in, load_main_skid, load_skid;

  assign accept    = in_valid && in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign xfer      = out_valid && out_ready;
  assign in_ready  = in_ready_q;

  // State register; in_ready is registered from the next state so out_ready never reaches it combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Next-state and entry load selection; flush overrides any transfer in the same cycle
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (accept && xfer) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: if (xfer) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Entry storage: main drives the outputs, skid holds the younger instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= dec_bus;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec_bus;
    end
  end

  assign {out_ctrl, out_rs1, out_rs2, out_rd, out_imm, out_pc,
          out_mem_read, out_mem_write, out_is_jump, out_illegal} = main_q;

endmodule
